// File: rtl/serial_collector_pkg.sv
// Shared types and constants for the serial word collector.
// Optional parity stage enabled by SERIAL_COLLECTOR_PARITY_CHECK_EN.
package serial_collector_pkg;

  localparam int DEFAULT_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PARITY  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Small synchronous FIFO for assembled words plus parity flag.
// Push while full is accepted only when a pop frees the slot.
module collector_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [NW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == NW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + NW'(1);
        2'b01:   r_cnt <= r_cnt - NW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Assembles strobed serial bits into words and queues them for the next stage.
// Define SERIAL_COLLECTOR_PARITY_CHECK_EN to expect a trailing even-parity bit.
module serial_word_collector
  import serial_collector_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                clock,
  input  logic                                resetN,
  input  logic                                enable,
  input  logic                                frameStart,
  input  logic                                bitValid,
  input  logic                                serialIn,
  input  logic                                lsbFirst,
  output logic [WORD_WIDTH-1:0]               wordData,
  output logic                                wordValid,
  input  logic                                wordReady,
  output logic                                parityError,
  output logic                                busy,
  output logic [cnt_width(WORD_WIDTH)-1:0]    bitCount,
  output logic                                overflow,
  output logic                                frameAbort,
  input  logic                                clearStatus
);

  localparam int CW = cnt_width(WORD_WIDTH);
  localparam logic [CW-1:0] LP_W = CW'(WORD_WIDTH);

  state_t                r_state;
  logic [CW-1:0]         r_count;
  logic [WORD_WIDTH-1:0] r_acc;
  logic                  r_lsb;
  logic                  r_ovf;
  logic                  r_abort;

  logic                  w_cap;
  logic                  w_start;
  logic                  w_lsb;
  logic [CW-1:0]         w_k;
  logic [CW-1:0]         w_idx;
  logic [WORD_WIDTH-1:0] w_acc;
  logic                  w_collect;
  logic                  w_done;
  logic                  w_par_bit;
  logic                  w_push;
  logic [WORD_WIDTH-1:0] w_push_word;
  logic                  w_push_par;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [WORD_WIDTH:0]   w_head;

  assign w_cap     = enable && bitValid;
  assign w_start   = w_cap && frameStart;
  assign w_collect = w_start || (w_cap && r_state == ST_COLLECT);
  assign w_done    = w_collect && (w_k == LP_W);

  always_comb begin
    w_lsb = w_start ? lsbFirst : r_lsb;
    w_k   = w_start ? CW'(1) : r_count + CW'(1);
    w_idx = w_lsb ? w_k - CW'(1) : LP_W - w_k;
    w_acc = w_start ? '0 : r_acc;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (CW'(i) == w_idx) w_acc[i] = serialIn;
    end
  end

`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
  assign w_par_bit   = w_cap && !frameStart && r_state == ST_PARITY;
  assign w_push      = w_par_bit;
  assign w_push_word = r_acc;
  assign w_push_par  = (^r_acc) ^ serialIn;
`else
  assign w_par_bit   = 1'b0;
  assign w_push      = w_done;
  assign w_push_word = w_acc;
  assign w_push_par  = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_acc   <= '0;
      r_lsb   <= 1'b0;
    end else begin
      unique case (1'b1)
        w_collect: begin
          r_acc   <= w_acc;
          r_lsb   <= w_lsb;
          r_count <= w_k;
          r_state <= ST_COLLECT;
          if (w_done) begin
`ifdef SERIAL_COLLECTOR_PARITY_CHECK_EN
            r_state <= ST_PARITY;
`else
            r_state <= ST_IDLE;
            r_count <= '0;
`endif
          end
        end
        w_par_bit: begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  // Same-edge events beat a clear request.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_ovf   <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_ovf   <= (w_push && w_full && !w_pop) || (r_ovf && !clearStatus);
      r_abort <= (w_start && r_state != ST_IDLE) || (r_abort && !clearStatus);
    end
  end

  collector_fifo #(
    .WIDTH (WORD_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetN  (resetN),
    .i_push  (w_push),
    .i_data  ({w_push_par, w_push_word}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop       = wordValid && wordReady;
  assign wordValid   = !w_empty;
  assign wordData    = w_head[WORD_WIDTH-1:0];
  assign parityError = w_head[WORD_WIDTH];
  assign busy        = (r_state != ST_IDLE);
  assign bitCount    = r_count;
  assign overflow    = r_ovf;
  assign frameAbort  = r_abort;

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the shift register's serial output stream.
- Assembles bits qualified by a strobe into WORD_WIDTH-bit words, in LSB-first or MSB-first order.
- Pushes completed words into a small output FIFO that the next pipeline stage drains through a valid/ready handshake.
- Reports FIFO overflow and aborted frames as sticky status.

Parameters:
- WORD_WIDTH, 16, bits per assembled word; matches the producer register size.
- FIFO_DEPTH, 2, output FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no bits are captured; the FIFO pop side still operates.
- frameStart  in  1  marks the first bit of a word; only meaningful together with bitValid.
- bitValid  in  1  serialIn holds a valid bit this cycle.
- serialIn  in  1  serial data bit.
- lsbFirst  in  1  1 = first bit is word bit 0; 0 = first bit is word bit WORD_WIDTH-1. Sampled when the first bit is captured.
- wordData  out  WORD_WIDTH  head-of-FIFO word.
- wordValid  out  1  FIFO not empty.
- wordReady  in  1  consumer accepts the head word.
- parityError  out  1  parity flag of the head word; tied 0 without the macro.
- busy  out  1  state is not IDLE.
- bitCount  out  $clog2(WORD_WIDTH+1)  bits captured in the current frame.
- overflow  out  1  sticky: a completed word was dropped.
- frameAbort  out  1  sticky: frameStart arrived mid-frame.
- clearStatus  in  1  synchronous clear of overflow and frameAbort.

Behaviour:
- Reset (async, resetN=0), all outputs forced immediately:
  - state=IDLE, bitCount=0, shift accumulator=0.
  - FIFO empty, wordValid=0, wordData=0, parityError=0.
  - overflow=0, frameAbort=0, busy=0.
- Capture condition: enable && bitValid. With enable=0, bits are ignored and the state is held.
- IDLE:
  - Capture with frameStart=1 stores the bit as bit #1, sets bitCount=1, latches lsbFirst and goes to COLLECT.
  - A capture without frameStart is discarded.
- COLLECT:
  - Each capture stores the next bit and increments bitCount.
  - On bit #WORD_WIDTH, the word is complete. Without the macro it is pushed on that same edge and the state returns to IDLE. With the macro the state goes to PARITY.
  - frameStart with a capture while in COLLECT (or PARITY) sets frameAbort, discards the partial word, and treats the current bit as bit #1 of a new frame.
- Bit placement:
  - lsbFirst=1: bit #k goes to word[k-1].
  - lsbFirst=0: bit #k goes to word[WORD_WIDTH-k].
- Latency: wordValid rises in the cycle after the completing edge, provided the FIFO was empty.
- FIFO handshake:
  - A pop occurs when wordValid && wordReady.
  - Push and pop on the same edge are always legal, including when the FIFO is full; the push is accepted.
  - Push while full with no pop drops the new word, sets overflow, and leaves the FIFO unchanged.
  - wordData and parityError always reflect the head entry; they are 0 when the FIFO is empty.
- Pointers wrap modulo FIFO_DEPTH. An extra occupancy counter distinguishes full from empty.
- clearStatus in the same cycle as a new overflow or abort event: the event wins and the flag stays 1.
- bitCount returns to 0 on the cycle the state reaches IDLE.

Optional Feature:
- Macro: SERIAL_COLLECTOR_PARITY_CHECK_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the data bits; the state sequence is IDLE -> COLLECT -> PARITY -> IDLE.
  - In PARITY, the next capture is the parity bit. The word is pushed with parityError = XOR(data bits, parity bit) on that edge.
  - frameStart in PARITY aborts the frame, as in COLLECT.
- Undefined: there is no PARITY state and parityError is constant 0.

Decomposition:
- Shared package serial_collector_pkg holds:
  - the state encoding (IDLE, COLLECT, PARITY);
  - the function that computes bitCount width;
  - the default WORD_WIDTH constant shared with the producer register.
- One sub-module, collector_fifo: synchronous FIFO of WORD_WIDTH+1 bits (data plus parity flag) with push/pop, full/empty and occupancy.

Test Plan:
- LSB-first, WORD_WIDTH=16: frameStart+16 strobed bits encoding 0xA5C3 (bit0 first), wordReady=1 -> wordValid=1 with wordData=0xA5C3 one cycle after the 16th bit; popped the following edge.
- MSB-first: same bit sequence with lsbFirst=0 -> wordData=0xC3A5, the bit-reversed value.
- Overflow: wordReady=0, three complete frames -> FIFO holds words 1 and 2, overflow=1, word 3 lost. Then clearStatus -> overflow=0. Full + simultaneous pop + push -> no overflow.
- Abort: frameStart, 7 bits, then frameStart again with 16 bits of 0x1234 -> frameAbort=1, single word 0x1234 output.
- Async reset mid-frame (bitCount=9, FIFO holding 1 word) -> outputs zero immediately without a clock edge. Post-reset bits without frameStart are ignored.
- With SERIAL_COLLECTOR_PARITY_CHECK_EN: 0x0001 followed by parity bit 1 -> parityError=0; followed by parity bit 0 -> parityError=1.
